pipeline_muldiv: RTL
====================

# pipeline_muldiv

Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers. It sits beside the ALU stage and receives MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from it through a valid/ready handshake. It computes multi-cycle results on operand magnitudes with sign fix-up, and exposes HI/LO plus a busy flag so that MFHI/MFLO consumers stall until results land.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1: quotient/multiplier bits retired per iteration; legal values 1, 2, 4; must divide WIDTH.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of the in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  unit accepts a request this cycle
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others illegal
- req_a  in  WIDTH  rs operand (dividend / multiplicand / MTHI, MTLO source)
- req_b  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  1  operation in flight; HI/LO are stale
- done  out  1  one-cycle pulse when HI/LO have been updated by MULT/DIV
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with req_b==0
- bad_op  out  1  one-cycle pulse after an illegal req_op is accepted
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIXUP.
- req_ready = (state==IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready.
- MTHI/MTLO: on the accept edge, hi_out/lo_out := req_a. The unit stays in IDLE, with no done and no busy.
- Illegal op: accepted, bad_op pulses for one cycle, HI/LO are unchanged, state stays IDLE.
- MULT/MULTU/DIV/DIVU, accept edge:
  - latch the magnitudes of req_a and req_b (signed ops: two's-complement absolute value; unsigned ops: raw value);
  - latch result sign flags;
  - set iteration counter to N = WIDTH/BITS_PER_CYCLE;
  - go to CALC.
- CALC, multiply: shift-add, BITS_PER_CYCLE multiplier bits per edge, into a 2·WIDTH accumulator.
- CALC, divide: restoring division, BITS_PER_CYCLE quotient bits per edge.
- The counter decrements on each CALC edge. When it reaches 0, the unit goes to FIXUP.
- FIXUP edge, multiply: {HI,LO} := product, negated if the signs of a and b differ (signed op only).
- FIXUP edge, divide:
  - LO := quotient, negated if sign(a)^sign(b);
  - HI := remainder, negated if sign(a).
- Signed MIN / -1: LO = MIN, HI = 0, with no exception. This falls out of WIDTH-bit wrap.
- Divide by zero (divisor latched as 0): iterations still run. At FIXUP, LO := all ones, HI := req_a (original, unsigned), and div_by_zero pulses.
- After the FIXUP edge: state := IDLE, done := 1 for one cycle.
- flush in CALC or FIXUP: state := IDLE on the next edge, with no done and HI/LO unchanged. flush in IDLE drops any presented request.
- All arithmetic is modulo 2·WIDTH for products and WIDTH for quotient/remainder. No overflow signalling.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, bad_op=0.
- Reset asserted mid-operation aborts immediately. HI/LO are cleared.
- busy = (state != IDLE); it is registered state, not combinational on req_valid.
- MULT/DIV latency: accept edge E0, CALC edges E1..EN, FIXUP edge EN+1. HI/LO, done=1 and busy=0 are visible in the cycle after EN+1.
- Total latency is N+1 edges after accept: 33 for WIDTH=32, BITS_PER_CYCLE=1; 9 for BITS_PER_CYCLE=4.
- Back-to-back: a new request can be accepted in the done cycle.
- MTHI/MTLO: value is visible the cycle after the accept edge.
- Only one operation is in flight; no queueing.

## Configuration
- PIPELINE_MULDIV_DIV_EN defined: full behaviour as above.
- PIPELINE_MULDIV_DIV_EN undefined:
  - divider datapath is removed;
  - DIV/DIVU are treated as illegal ops (bad_op pulse, HI/LO unchanged);
  - div_by_zero is tied 0;
  - MULT/MULTU/MTHI/MTLO are unchanged.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFF1, done one cycle, busy high for the 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; repeat with BITS_PER_CYCLE=4 -> same result at 9 edges.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero and done pulse together.
- MTLO 0xAA, then DIVU 9/2 with flush at CALC cycle 10 -> returns to IDLE, no done, LO stays 0xAA. A following DIVU 9/2 -> LO=4, HI=1. Separately, rst_n low mid-MULT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_muldiv.sv
// pipeline_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and a valid/ready request port.
// Define PIPELINE_MULDIV_DIV_EN to build the divider; without it DIV/DIVU are reported as illegal ops.
module pipeline_muldiv #(
  parameter int WIDTH = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             bad_op,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
`ifdef PIPELINE_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH-1:0] mb, a_orig, q, r;
  logic [WIDTH:0] s;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, sgn, start;
  assign req_ready = state == IDLE && !flush;
  assign busy = state != IDLE;
  assign sgn = !req_op[0] && !req_op[2];
  assign start = req_valid && req_ready && !req_op[2] && (DIV_EN || !req_op[1]);
  assign q = acc[WIDTH-1:0];
  assign r = acc[2*WIDTH-1:WIDTH];
  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    nxt = acc;
    s = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef PIPELINE_MULDIV_DIV_EN
      if (is_div) begin
        s = {nxt[2*WIDTH-1:WIDTH], nxt[WIDTH-1]} - {1'b0, mb};
        nxt = {s[WIDTH] ? {nxt[2*WIDTH-2:WIDTH], nxt[WIDTH-1]} : s[WIDTH-1:0], nxt[WIDTH-2:0], ~s[WIDTH]};
      end else
`endif
      begin
        s = {1'b0, nxt[2*WIDTH-1:WIDTH]} + (nxt[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
        nxt = {s, nxt[WIDTH-1:1]};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      mb <= '0;
      a_orig <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op <= 1'b0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op <= 1'b0;
      if (start) begin
        state <= CALC;
        cnt <= CW'(N);
        is_div <= req_op[1];
        neg_q <= sgn && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
        neg_r <= sgn && req_a[WIDTH-1];
        a_orig <= req_a;
        acc <= {{WIDTH{1'b0}}, (sgn && req_a[WIDTH-1] ? -req_a : req_a)};
        mb <= sgn && req_b[WIDTH-1] ? -req_b : req_b;
      end else if (req_valid && req_ready) begin
        if (req_op == 3'd4) hi_out <= req_a;
        else if (req_op == 3'd5) lo_out <= req_a;
        else bad_op <= 1'b1;
      end
      if (flush) state <= IDLE;
      else if (state == CALC) begin
        acc <= nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= FIXUP;
      end else if (state == FIXUP) begin
        state <= IDLE;
        done <= 1'b1;
        if (is_div) begin
          lo_out <= mb == '0 ? '1 : neg_q ? -q : q;
          hi_out <= mb == '0 ? a_orig : neg_r ? -r : r;
          div_by_zero <= mb == '0;
        end else {hi_out, lo_out} <= neg_q ? -acc : acc;
      end
    end
  end
endmodule
